// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   arb_owner_t : which port owns the read response returning next cycle
//   BE_W        : byte-enable width of the memory port
//   BE_ALL      : byte enables driven for every read access
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  localparam int unsigned BE_W = 4;
  localparam logic [BE_W-1:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_starve.sv
// Fetch starvation guard for mem_arbiter (only instantiated when ARB_STARVE_GUARD_EN is defined).
// Counts consecutive denied fetch cycles, saturating at MAX_WAIT; force_if is high while the
// count sits at MAX_WAIT so fetch wins the next contended cycle.
// Ports:
//   clk, reset (sync, active-high)
//   if_req, if_gnt : fetch request and grant of the current cycle
//   force_if       : fetch must win arbitration this cycle
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam int unsigned CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MaxCnt) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, word-addressed, 1-cycle-latency memory between the
// instruction-fetch port and the load/store data port. Data has priority over fetch; read data
// is steered back to the port that owned the read. Optional fetch starvation guard is enabled by
// defining ARB_STARVE_GUARD_EN (otherwise MAX_WAIT is ignored).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        : fetch request / accept
//   if_rvalid/if_rdata              : fetch read response (cycle after grant)
//   d_req/d_we/d_addr/d_wdata/d_be  : data request; d_gnt accepts it
//   d_rvalid/d_rdata                : load response (cycle after grant, never for stores)
//   mem_en/we/be/addr/wdata, mem_rdata : memory port
//   stall                           : fetch waiting (if_req & ~if_gnt)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  arb_owner_t owner_d, owner_q;
  logic       force_if;

`ifdef ARB_STARVE_GUARD_EN
  mem_arb_starve #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .force_if(force_if)
  );
`else
  assign force_if = 1'b0;
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
`endif

  // Grants are suppressed for the whole reset cycle so nothing reaches the memory.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && (force_if || !d_req)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = BE_ALL;
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_en   = 1'b1;
      mem_we   = d_we;
      mem_addr = d_addr;
      if (d_we) begin
        mem_be    = d_be;
        mem_wdata = d_wdata;
      end else begin
        mem_be = BE_ALL;
      end
    end
  end

  // Owner only tracks reads; a store grant leaves nothing in flight.
  always_comb begin
    owner_d = OWN_IDLE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // A response owned at the moment reset is asserted is dropped, not delivered.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!reset) begin
      unique case (owner_q)
        OWN_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        OWN_D: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign stall = if_req & ~if_gnt & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural write-first memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] exp;

  logic [118:0] all_out;
  assign all_out = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
                    mem_be, mem_addr, mem_wdata, stall};

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall    (stall)
  );

  // Memory model with a side port for preloading while the arbiter is idle.
  logic [DW-1:0] mem_arr [0:4095];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem_arr[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem_arr[mem_addr];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_addr = a;
    pre_data = v;
    pre_we   = 1'b1;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    if_req = 1'b1; if_addr = 12'h010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h010; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL idle_outputs: got %h expected 0", all_out);
    end
    next_cycle();
  endtask

  task automatic test_fetch_only();
    exp_if_q.delete();
    preload(12'h010, 32'h0050_0093);
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clk);
    n_vec++;
    if ({if_gnt, stall, mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'h010}) begin
      n_err++;
      $display("FAIL fetch_grant: got gnt=%b stall=%b en=%b we=%b be=%h addr=%h expected 1 0 1 0 f 010",
               if_gnt, stall, mem_en, mem_we, mem_be, mem_addr);
    end
    if (if_gnt) exp_if_q.push_back(32'h0050_0093);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL fetch_rvalid: got if=%b d=%b expected 1 0", if_rvalid, d_rvalid);
    end else if (exp_if_q.size() == 0) begin
      n_err++; $display("FAIL fetch_unexpected: got rvalid expected no response");
    end else begin
      exp = exp_if_q.pop_front();
      if (if_rdata !== exp) begin
        n_err++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, exp);
      end
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL fetch_done_idle: got %h expected 0", all_out);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    exp_if_q.delete();
    preload(12'h020, 32'h1357_9BDF);
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clk);
    if (if_gnt) exp_if_q.push_back(32'h0050_0093);
    next_cycle();
    if_addr = 12'h020;
    @(negedge clk);
    n_vec++;
    if (if_gnt !== 1'b1 || mem_addr !== 12'h020) begin
      n_err++; $display("FAIL b2b_grant: got gnt=%b addr=%h expected 1 020", if_gnt, mem_addr);
    end
    if (if_rvalid !== 1'b1 || exp_if_q.size() == 0) begin
      n_err++; $display("FAIL b2b_rvalid0: got %b expected 1", if_rvalid);
    end else begin
      exp = exp_if_q.pop_front();
      if (if_rdata !== exp) begin
        n_err++; $display("FAIL b2b_rdata0: got %h expected %h", if_rdata, exp);
      end
    end
    if (if_gnt) exp_if_q.push_back(32'h1357_9BDF);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (if_rvalid !== 1'b1 || exp_if_q.size() == 0) begin
      n_err++; $display("FAIL b2b_rvalid1: got %b expected 1", if_rvalid);
    end else begin
      exp = exp_if_q.pop_front();
      if (if_rdata !== exp) begin
        n_err++; $display("FAIL b2b_rdata1: got %h expected %h", if_rdata, exp);
      end
    end
    next_cycle();
  endtask

  task automatic test_contention();
    exp_if_q.delete();
    exp_d_q.delete();
    preload(12'h200, 32'hCAFE_F00D);
    if_req = 1'b1; if_addr = 12'h020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h200;
    @(negedge clk);
    n_vec++;
    if ({d_gnt, if_gnt, stall, mem_addr, mem_be} !== {1'b1, 1'b0, 1'b1, 12'h200, 4'hF}) begin
      n_err++;
      $display("FAIL cont_grant: got dg=%b ig=%b stall=%b addr=%h be=%h expected 1 0 1 200 f",
               d_gnt, if_gnt, stall, mem_addr, mem_be);
    end
    if (d_gnt) exp_d_q.push_back(32'hCAFE_F00D);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || exp_d_q.size() == 0) begin
      n_err++; $display("FAIL cont_d_rvalid: got d=%b if=%b expected 1 0", d_rvalid, if_rvalid);
    end else begin
      exp = exp_d_q.pop_front();
      if (d_rdata !== exp || if_rdata !== '0) begin
        n_err++; $display("FAIL cont_d_rdata: got %h/%h expected %h/0", d_rdata, if_rdata, exp);
      end
    end
    n_vec++;
    if (if_gnt !== 1'b1 || stall !== 1'b0 || mem_addr !== 12'h020) begin
      n_err++; $display("FAIL cont_if_grant: got gnt=%b stall=%b addr=%h expected 1 0 020",
                        if_gnt, stall, mem_addr);
    end
    if (if_gnt) exp_if_q.push_back(32'h1357_9BDF);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || exp_if_q.size() == 0) begin
      n_err++; $display("FAIL cont_if_rvalid: got if=%b d=%b expected 1 0", if_rvalid, d_rvalid);
    end else begin
      exp = exp_if_q.pop_front();
      if (if_rdata !== exp || d_rdata !== '0) begin
        n_err++; $display("FAIL cont_if_rdata: got %h/%h expected %h/0", if_rdata, d_rdata, exp);
      end
    end
    next_cycle();
  endtask

  // Store of wdata with byte enables be, then a load of the same word expecting want.
  task automatic store_then_load(input string name, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wdata, input logic [3:0] be,
                                 input logic [DW-1:0] want);
    exp_d_q.delete();
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wdata; d_be = be;
    @(negedge clk);
    n_vec++;
    if ({d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, be, a, wdata}) begin
      n_err++;
      $display("FAIL %s_store: got gnt=%b en=%b we=%b be=%h addr=%h wd=%h expected 1 1 1 %h %h %h",
               name, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata, be, a, wdata);
    end
    next_cycle();
    d_we = 1'b0; d_wdata = '0; d_be = '0;
    @(negedge clk);
    n_vec++;
    if (d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL %s_store_rvalid: got %b expected 0", name, d_rvalid);
    end
    n_vec++;
    if ({d_gnt, mem_we, mem_be} !== {1'b1, 1'b0, 4'hF}) begin
      n_err++; $display("FAIL %s_load_grant: got gnt=%b we=%b be=%h expected 1 0 f",
                        name, d_gnt, mem_we, mem_be);
    end
    if (d_gnt) exp_d_q.push_back(want);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (d_rvalid !== 1'b1 || exp_d_q.size() == 0) begin
      n_err++; $display("FAIL %s_load_rvalid: got %b expected 1", name, d_rvalid);
    end else begin
      exp = exp_d_q.pop_front();
      if (d_rdata !== exp) begin
        n_err++; $display("FAIL %s_load_rdata: got %h expected %h", name, d_rdata, exp);
      end
    end
    next_cycle();
  endtask

  task automatic test_store_load();
    store_then_load("full", 12'h040, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    preload(12'h041, 32'h1122_3344);
    store_then_load("partial", 12'h041, 32'hAABB_CCDD, 4'b0011, 32'h1122_CCDD);
  endtask

  task automatic test_starvation();
    bit granted;
    exp_if_q.delete();
    preload(12'h030, 32'h0BAD_F00D);
    granted = 1'b0;
    if_req = 1'b1; if_addr = 12'h030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h050;
    for (int c = 0; c < 8 && !granted; c++) begin
      @(negedge clk);
      n_vec++;
`ifdef ARB_STARVE_GUARD_EN
      if (c < 4) begin
        if ({if_gnt, d_gnt, stall} !== 3'b011) begin
          n_err++; $display("FAIL starve_deny%0d: got ig=%b dg=%b stall=%b expected 0 1 1",
                            c, if_gnt, d_gnt, stall);
        end
      end else begin
        if ({if_gnt, d_gnt, stall} !== 3'b100) begin
          n_err++; $display("FAIL starve_force%0d: got ig=%b dg=%b stall=%b expected 1 0 0",
                            c, if_gnt, d_gnt, stall);
        end
      end
`else
      if ({if_gnt, d_gnt, stall} !== 3'b011) begin
        n_err++; $display("FAIL starve_strict%0d: got ig=%b dg=%b stall=%b expected 0 1 1",
                          c, if_gnt, d_gnt, stall);
      end
`endif
      if (if_gnt) begin
        granted = 1'b1;
        exp_if_q.push_back(32'h0BAD_F00D);
      end
      next_cycle();
      if (granted) if_req = 1'b0;
    end
`ifdef ARB_STARVE_GUARD_EN
    @(negedge clk);
    n_vec++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || exp_if_q.size() == 0) begin
      n_err++; $display("FAIL starve_rvalid: got if=%b d=%b expected 1 0", if_rvalid, d_rvalid);
    end else begin
      exp = exp_if_q.pop_front();
      if (if_rdata !== exp) begin
        n_err++; $display("FAIL starve_rdata: got %h expected %h", if_rdata, exp);
      end
    end
    next_cycle();
`endif
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clk);
    n_vec++;
    if (if_gnt !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_grant: got %b expected 1", if_gnt);
    end
    next_cycle();
    // Requests stay high through reset; nothing may leak out.
    reset = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h010; d_wdata = 32'h0; d_be = 4'hF;
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %h expected 0", all_out);
    end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL rst_mid_after: got %h expected 0", all_out);
    end
    next_cycle();
    // The store presented during reset must not have reached memory.
    exp_if_q.delete();
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clk);
    if (if_gnt) exp_if_q.push_back(32'h0050_0093);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (if_rvalid !== 1'b1 || exp_if_q.size() == 0) begin
      n_err++; $display("FAIL rst_mid_reread_rvalid: got %b expected 1", if_rvalid);
    end else begin
      exp = exp_if_q.pop_front();
      if (if_rdata !== exp) begin
        n_err++; $display("FAIL rst_mid_reread: got %h expected %h", if_rdata, exp);
      end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_back_to_back();
    test_contention();
    test_store_load();
    test_starvation();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter sharing one single-port, word-addressed memory between the instruction-fetch port and the load/store data port of the RV32I core. Sits between PC/fetch logic, the load/store path and the unified memory. Grants one access per cycle, steers the 1-cycle-latency read data back to the owning port, and drives `stall` to freeze the PC while fetch waits.

## Interface
- `ADDR_W`, 12, word-address width.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, consecutive denied fetch cycles before fetch is forced to win. Used only with `ARB_STARVE_GUARD_EN`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch read request. Held with stable `if_addr` until `if_gnt`.
- `if_addr` in ADDR_W: fetch word address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out DATA_W: fetch data.
- `d_req` in 1: data request. Held with stable addr, we, wdata and be until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in DATA_W: store data.
- `d_be` in 4: store byte enables.
- `d_gnt` out 1: data accepted this cycle.
- `d_rvalid` out 1: load data valid. Never asserted for stores.
- `d_rdata` out DATA_W: load data.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after a read with `mem_en=1, mem_we=0`.
- `stall` out 1: `if_req & ~if_gnt`.

## Operation
- Grant logic is combinational in the request cycle. At most one of `if_gnt`/`d_gnt` is high in any cycle.
- The granted request drives the `mem_*` outputs in the same cycle. With no grant, `mem_en=0` and the other `mem_*` outputs are 0.
- Default priority: data wins over fetch.
- Owner register: IDLE, RD_IF, RD_D. Next state:
  - IDLE after any cycle with no read grant, including cycles with a store grant.
  - RD_IF after a fetch grant.
  - RD_D after a data load grant.
- Response steering:
  - In RD_IF: `if_rvalid=1`, `if_rdata=mem_rdata`.
  - In RD_D: `d_rvalid=1`, `d_rdata=mem_rdata`.
  - A non-owning port sees rvalid 0 and rdata 0.
- A new grant is allowed in the same cycle a response returns, so back-to-back accesses run at full throughput.
- Stores complete in the grant cycle. Read-after-write to the same address returns the new data because the memory is write-first.
- Stores use `d_be` for byte enables. Loads drive `mem_be=4'hF`.
- Reset, including mid-operation: the owner register goes to IDLE and any in-flight read is discarded, so no rvalid appears in the following cycle. Outputs are held at 0 for the whole reset cycle, regardless of requests.

## Timing
- Reset values: all outputs 0, owner IDLE, starvation counter 0.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1 only.
- Store latency: 0. The write happens at the clock edge ending the grant cycle.
- Contention (both requests in the same cycle): the data port is granted. Fetch is granted on the first cycle `d_req=0`. `stall=1` for every denied fetch cycle.
- Handshake rule: a requester may not change its request fields while `req=1` and `gnt=0`. Dropping `req` before grant is allowed and aborts the request cleanly.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A saturating counter (0..MAX_WAIT) increments on every cycle with `if_req & ~if_gnt`.
  - It clears on `if_gnt`, when `if_req=0`, or on `reset`.
  - When the counter equals MAX_WAIT, fetch wins the next contended cycle.
- `ARB_STARVE_GUARD_EN` undefined: strict data priority, no counter in the design, and `MAX_WAIT` is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - owner typedef `arb_owner_t` {OWN_IDLE, OWN_IF, OWN_D};
  - constant `BE_W=4`;
  - constant `BE_ALL=4'hF`.
- One sub-module, `mem_arb_starve`: the saturating wait counter and the `force_if` output. It is instantiated only under `ARB_STARVE_GUARD_EN`.
- Grant logic, owner register and response steering stay in the top module.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x010`, memory holds 0x00500093.
  - Cycle 0: `if_gnt=1`, `mem_addr=0x010`, `stall=0`.
  - Cycle 1: `if_rvalid=1`, `if_rdata=0x00500093`.
- Contention: `if_req` and `d_req` (load, addr 0x200) high together.
  - Cycle 0: `d_gnt=1`, `stall=1`.
  - Cycle 1: `d_rvalid=1` with the 0x200 data, and `if_gnt=1` in the same cycle.
  - Cycle 2: `if_rvalid=1`.
- Store then load, same address: store 0xDEADBEEF to 0x040 with `d_be=4'hF`, then a load from 0x040.
  - Store cycle: no `d_rvalid`.
  - Load: `d_rdata=0xDEADBEEF` one cycle after its grant.
- Partial store: memory at 0x041 holds 0x11223344. Store 0xAABBCCDD with `d_be=4'b0011`, then read 0x041: returns 0x1122CCDD.
- Starvation, with the macro and `MAX_WAIT=4`: `d_req` held high continuously with fetch pending.
  - Fetch is denied for 4 cycles.
  - Cycle 4: `if_gnt=1`, `d_gnt=0`.
  - Without the macro: fetch is never granted and `stall` stays 1.
- Reset mid-read: fetch granted in cycle N, `reset=1` in cycle N+1.
  - `if_rvalid=0` in cycle N+1; all outputs are 0 during reset.
  - Cycle N+2, reset released with no requests: everything is 0 and the owner is IDLE.
